// File: rtl/int2float_pkg.sv
// Shared defaults for the integer-to-compressed-float arbiter and its converter.
// The requester-index width helper is also used for the converter's bit-position width.
package int2float_pkg;

  localparam int IN_W_DEF  = 11;
  localparam int OUT_W_DEF = 7;
  localparam int EXP_W     = 3;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/int2float_core.sv
// Unsigned integer to {exponent, mantissa} float, mantissa truncated:
// values below 2^MAN_W pass through with exponent 0, otherwise value ~= mantissa << exponent.
module int2float_core
  import int2float_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [IN_W-1:0]  operand,
  output logic [OUT_W-1:0] result
);

  localparam int MAN_W = OUT_W - EXP_W;
  localparam int POS_W = idx_w(IN_W);

  logic [POS_W-1:0] msb_s;
  logic [POS_W-1:0] shift_s;
  logic [IN_W-1:0]  shifted_s;
  logic [EXP_W-1:0] exp_s;
  logic [MAN_W-1:0] man_s;

  // Leading-one search, then keep the MAN_W bits starting at the leading one.
  always_comb begin
    msb_s     = '0;
    shift_s   = '0;
    shifted_s = '0;
    exp_s     = '0;
    man_s     = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (operand[i]) begin
        msb_s = POS_W'(i);
      end else begin
        msb_s = msb_s;
      end
    end
    if (msb_s < POS_W'(MAN_W)) begin
      exp_s = '0;
      man_s = operand[MAN_W-1:0];
    end else begin
      shift_s   = msb_s - POS_W'(MAN_W - 1);
      shifted_s = operand >> shift_s;
      exp_s     = EXP_W'(shift_s);
      man_s     = shifted_s[MAN_W-1:0];
    end
  end

  assign result = {exp_s, man_s};

endmodule

// File: rtl/int2float_arbiter.sv
// Round-robin arbiter sharing one int2float converter among NUM_REQ requesters,
// with a single registered output stage that drains and reloads in the same cycle.
module int2float_arbiter
  import int2float_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = IN_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*IN_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [idx_w(NUM_REQ)-1:0]  out_id,
  output logic [15:0]                accept_cnt
);

  localparam int ID_W = idx_w(NUM_REQ);

  logic [ID_W-1:0]    last_grant_r;
  logic [ID_W-1:0]    grant_idx_s;
  logic [ID_W-1:0]    cand_s;
  logic               grant_found_s;
  logic               can_load_s;
  logic               handshake_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IN_W-1:0]    operand_s;
  logic [OUT_W-1:0]   result_s;

  assign can_load_s  = !out_valid || out_ready;
  assign handshake_s = |(req_valid & req_ready);

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant_idx_s   = '0;
    grant_found_s = 1'b0;
    cand_s        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = ID_W'((int'(last_grant_r) + k) % NUM_REQ);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot grant, gated by output-stage space; nothing is offered during reset.
  always_comb begin
    grant_s = '0;
    if (grant_found_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    if (can_load_s && !rst) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operand mux feeding the shared converter.
  always_comb begin
    operand_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == ID_W'(i)) begin
        operand_s = req_data[i*IN_W +: IN_W];
      end else begin
        operand_s = operand_s;
      end
    end
  end

  int2float_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .operand (operand_s),
    .result  (result_s)
  );

  // Output register, grant pointer and accept counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_id       <= '0;
      accept_cnt   <= 16'd0;
      last_grant_r <= ID_W'(NUM_REQ - 1);
    end else if (handshake_s) begin
      out_valid    <= 1'b1;
      out_data     <= result_s;
      out_id       <= grant_idx_s;
      accept_cnt   <= accept_cnt + 16'd1;
      last_grant_r <= grant_idx_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_int2float_arbiter.sv
// Directed bench for int2float_arbiter: reset, rotation, backpressure,
// sparse wrap, counter wrap and mid-operation reset.
module tb_int2float_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [43:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [1:0]  out_id;
  logic [15:0] accept_cnt;

  logic [10:0] opnd [4];
  int n_vec = 0;
  int n_err = 0;

  assign req_data = {opnd[3], opnd[2], opnd[1], opnd[0]};

  always #5 clk = ~clk;

  int2float_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .accept_cnt (accept_cnt)
  );

  // Reference converter: halve until the value fits in 4 bits, counting halvings.
  function automatic logic [6:0] golden(input logic [10:0] x);
    logic [10:0] v;
    logic [2:0]  e;
    v = x;
    e = 3'd0;
    while (v >= 11'd16) begin
      v = v >> 1;
      e = e + 3'd1;
    end
    return {e, v[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b0;
    opnd[0]   = 11'd5;
    opnd[1]   = 11'd16;
    opnd[2]   = 11'd2047;
    opnd[3]   = 11'd100;

    // Reset held two cycles with every requester asking
    step();
    check("rst_ready_c1", req_ready, 4'b0000);
    step();
    check("rst_ready_c2", req_ready, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 7'h00);
    check("rst_id", out_id, 2'd0);
    check("rst_cnt", accept_cnt, 16'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_cnt", accept_cnt, 16'd0);

    // Rotation with continuous drain
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rot_valid", out_valid, 1'b1);
      check("rot_id", out_id, k % 4);
      check("rot_data", out_data, golden(opnd[k % 4]));
    end
    check("rot_cnt", accept_cnt, 16'd8);

    // Backpressure: output holds id 3 (operand 100)
    req_valid = 4'b0110;
    out_ready = 1'b0;
    #1;
    check("bp_ready0", req_ready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ready", req_ready, 4'b0000);
      check("bp_valid", out_valid, 1'b1);
      check("bp_id", out_id, 2'd3);
      check("bp_data", out_data, 7'h3C);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 4'b0010);
    step();
    check("bp_id1", out_id, 2'd1);
    check("bp_data1", out_data, 7'h18);
    check("bp_ready_next", req_ready, 4'b0100);
    step();
    check("bp_id2", out_id, 2'd2);
    check("bp_data2", out_data, 7'h7F);
    check("bp_cnt", accept_cnt, 16'd10);

    // Sparse: only requester 3 asks
    req_valid = 4'b1000;
    step();
    check("sp_id_a", out_id, 2'd3);
    check("sp_data_a", out_data, 7'h3C);
    opnd[3] = 11'h400;
    #1;
    check("sp_ready_wrap", req_ready, 4'b1000);
    step();
    check("sp_id_b", out_id, 2'd3);
    check("sp_data_b", out_data, 7'h78);
    check("sp_cnt", accept_cnt, 16'd12);
    req_valid = 4'b0000;
    step();
    check("drain_valid", out_valid, 1'b0);
    check("drain_cnt", accept_cnt, 16'd12);

    // Counter wrap: run up to 0xFFFF, then two more handshakes
    req_valid = 4'b1111;
    for (int k = 0; k < 65523; k++) begin
      @(posedge clk);
    end
    #1;
    check("wrap_ffff", accept_cnt, 16'hFFFF);
    step();
    check("wrap_0000", accept_cnt, 16'h0000);
    step();
    check("wrap_0001", accept_cnt, 16'h0001);
    check("wrap_id", out_id, 2'd0);

    // Reset mid-operation with a stalled result pending
    out_ready = 1'b0;
    #1;
    check("mid_pending", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 4'b0000);
    step();
    check("mid_valid", out_valid, 1'b0);
    check("mid_cnt", accept_cnt, 16'd0);
    check("mid_id", out_id, 2'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_ready", req_ready, 4'b0001);
    step();
    check("mid_grant_id", out_id, 2'd0);
    check("mid_grant_data", out_data, 7'h05);
    check("mid_grant_cnt", accept_cnt, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int2float_arbiter.md
INT2FLOAT_ARBITER -- requirements
Module: int2float_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesters sharing the converter (2..8).
REQ-002 SHALL have parameter IN_W, default 11, meaning integer operand width.
REQ-003 SHALL have parameter OUT_W, default 7, meaning compressed-float result width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ, meaning per-requester operand valid.
REQ-007 SHALL have port req_data, input, NUM_REQ*IN_W, meaning operands; requester i occupies bits [i*IN_W +: IN_W].
REQ-008 SHALL have port req_ready, output, NUM_REQ, meaning per-requester accept.
REQ-009 SHALL have port out_valid, output, 1, meaning result register holds a valid result.
REQ-010 SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-011 SHALL have port out_data, output, OUT_W, meaning converted result.
REQ-012 SHALL have port out_id, output, clog2(NUM_REQ), meaning index of the requester that owns out_data.
REQ-013 SHALL have port accept_cnt, output, 16, meaning total accepted operands, wraps modulo 2^16.

Function
REQ-014 SHALL compute can_load = !out_valid | out_ready each cycle.
REQ-015 SHALL grant round-robin: first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
REQ-016 SHALL drive req_ready[i] = can_load & grant[i]; at most one req_ready bit high per cycle; req_ready combinational from req_valid, out_valid, out_ready, last_grant.
REQ-017 SHALL perform a handshake on requester i when req_valid[i] & req_ready[i]; req_data sampled only on that cycle.
REQ-018 SHALL, on handshake, load out_data = conversion of granted operand, out_id = granted index, out_valid = 1 at next edge (latency 1 cycle).
REQ-019 SHALL update last_grant to the granted index only on a handshake; no update when idle or stalled.
REQ-020 SHALL clear out_valid at next edge when out_valid & out_ready and no handshake occurs.
REQ-021 SHALL hold out_data and out_id stable while out_valid & !out_ready.
REQ-022 SHALL sustain one result per cycle when out_ready held high (drain and reload same cycle).
REQ-023 SHALL increment accept_cnt by 1 per handshake; 0xFFFF + 1 wraps to 0x0000.
REQ-024 SHALL guarantee each continuously valid requester is accepted within NUM_REQ handshakes.
REQ-025 SHALL treat a requester dropping req_valid before handshake as withdrawal, no result produced.

Reset
REQ-026 SHALL, when rst high at a clock edge, set out_valid=0, out_data=0, out_id=0, accept_cnt=0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-027 SHALL hold req_ready all-zero while rst is high.
REQ-028 SHALL discard any result pending in the output register when reset is asserted mid-operation; no handshake completes in a reset cycle.

Structure
REQ-029 SHALL place IN_W/OUT_W defaults and the requester-index width function in shared package int2float_pkg.
REQ-030 SHALL instantiate exactly one combinational converter sub-module int2float_core (IN_W in, OUT_W out) fed by the grant mux.
REQ-031 SHALL register only the output stage; no input buffering, no combinational path from req_data to out_data ports.

Verification
REQ-032 SHALL test reset: rst high 2 cycles, all req_valid=1 -> req_ready=0000 during reset; first cycle after, req_ready=0001, out_valid=0, accept_cnt=0.
REQ-033 SHALL test rotation: req_valid=1111, out_ready=1, 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, accept_cnt=8, out_data equal to int2float_core golden model per operand.
REQ-034 SHALL test backpressure: one result accepted, out_ready=0 for 5 cycles with req_valid=0110 -> req_ready=0000, out_data/out_id unchanged; out_ready=1 -> next out_id=1 then 2.
REQ-035 SHALL test sparse requests: only req_valid[3]=1 after last_grant=3 -> grant wraps to 3, out_id=3 one cycle later.
REQ-036 SHALL test counter wrap: 65537 handshakes -> accept_cnt=0x0001.
REQ-037 SHALL test reset mid-operation: out_valid=1, out_ready=0, rst pulsed 1 cycle -> out_valid=0 next cycle, next grant goes to requester 0.
